// File: rtl/pipearch_pkg.sv
// Shared types and constants for the pipearch modify stage.
package pipearch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } t_modify_state;

    localparam logic        MODIFY_LINREG = 1'b0;
    localparam logic        MODIFY_HINGE  = 1'b1;
    localparam logic [31:0] FIXED_ONE     = 32'h00010000;

    // Signed fixed-point multiply: full 64-bit product, arithmetic shift
    // (rounds toward -inf), low 32 bits kept with no saturation.
    function automatic logic [31:0] q_mul(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int          frac);
        logic signed [63:0] prod;
        prod = 64'($signed(a)) * 64'($signed(b));
        return 32'(prod >>> frac);
    endfunction

endpackage

// File: rtl/fifobram_interface.sv
// FIFO/BRAM port bundle: read side (re/rvalid/rdata/empty) and write side
// (we/wdata/almostfull). Read data follows re by one cycle.
interface fifobram_interface;
    logic        re;
    logic        rvalid;
    logic [31:0] rdata;
    logic        empty;
    logic        we;
    logic [31:0] wdata;
    logic        almostfull;

    modport fifo_read  (output re, input rvalid, input rdata, input empty);
    modport fifo_write (output we, output wdata, input almostfull);
endinterface

// File: rtl/pipearch_modify_datapath.sv
// Two-stage gradient datapath: S1 forms the residual / hinge subgradient,
// S2 scales it by the step size.
module pipearch_modify_datapath
    import pipearch_pkg::*;
#(
    parameter int FRAC_BITS = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_vld,
    input  logic        mode,
    input  logic [31:0] step,
    input  logic [31:0] dot,
    input  logic [31:0] label,
    output logic        out_vld,
    output logic [31:0] out_data
);

    localparam int STAGES = 2;

    logic [STAGES:1] vld_pipe;
    logic [31:0]     margin;
    logic [31:0]     diff_nxt;
    logic [31:0]     s1_diff;

    // S1 combinational: residual for linreg, -label inside the margin for hinge
    always_comb begin
        margin   = label[31] ? -dot : dot;
        diff_nxt = dot - label;
        if (mode == MODIFY_HINGE)
            diff_nxt = ($signed(margin) < $signed(FIXED_ONE)) ? -label : '0;
    end

    // Valid shift register plus the S1/S2 data registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld_pipe <= '0;
            s1_diff  <= '0;
            out_data <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_vld};
            if (in_vld)
                s1_diff <= diff_nxt;
            if (vld_pipe[1])
                out_data <= q_mul(s1_diff, step, FRAC_BITS);
        end
    end

    assign out_vld = vld_pipe[STAGES];

endmodule

// File: rtl/pipearch_modify.sv
// Modify stage: reads dot results and labels in lockstep, emits one
// step-scaled gradient scalar per sample, pulses op_done when all are written.
module pipearch_modify
    import pipearch_pkg::*;
#(
    parameter int FRAC_BITS        = 16,
    parameter int NUM_VALUES_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    op_start,
    output logic                    op_done,
    input  logic [31:0]             regs0,
    input  logic [31:0]             regs1,
    fifobram_interface.fifo_read    dot_input,
    fifobram_interface.fifo_read    labels_input,
    fifobram_interface.fifo_write   modify_output
);

    t_modify_state               state;
    logic [NUM_VALUES_WIDTH-1:0] num_values;
    logic [NUM_VALUES_WIDTH-1:0] requested;
    logic [NUM_VALUES_WIDTH-1:0] written;
    logic [NUM_VALUES_WIDTH-1:0] written_nxt;
    logic                        mode;
    logic [31:0]                 step;
    logic                        rd_fire;
    logic                        dp_in_vld;
    logic                        dp_vld;
    logic [31:0]                 dp_data;
    logic                        unused_regs0;

    assign unused_regs0 = ^regs0[31:17];

    // Reads are combinational so empty/almostfull are honoured in the same
    // cycle; a registered re would over-read a FIFO holding one entry.
    // Gating with resetn keeps the FIFOs untouched while reset is held.
    assign rd_fire = resetn && (state == RUN) && !dot_input.empty && !labels_input.empty
                     && !modify_output.almostfull && (requested < num_values);

    assign dot_input.re    = rd_fire;
    assign labels_input.re = rd_fire;

    // Late rvalids from reads issued before a reset are dropped in IDLE
    assign dp_in_vld   = dot_input.rvalid && labels_input.rvalid && (state != IDLE);
    assign written_nxt = written + NUM_VALUES_WIDTH'(dp_vld);

    pipearch_modify_datapath #(
        .FRAC_BITS (FRAC_BITS)
    ) u_datapath (
        .clk      (clk),
        .resetn   (resetn),
        .in_vld   (dp_in_vld),
        .mode     (mode),
        .step     (step),
        .dot      (dot_input.rdata),
        .label    (labels_input.rdata),
        .out_vld  (dp_vld),
        .out_data (dp_data)
    );

    assign modify_output.we    = dp_vld;
    assign modify_output.wdata = dp_data;

    // Operation FSM and request/write counters; op_done lands the cycle
    // after the final write
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            op_done    <= 1'b0;
            num_values <= '0;
            requested  <= '0;
            written    <= '0;
            mode       <= MODIFY_LINREG;
            step       <= '0;
        end else begin
            op_done <= 1'b0;
            written <= written_nxt;
            case (state)
                IDLE: begin
                    if (op_start) begin
                        num_values <= regs0[NUM_VALUES_WIDTH-1:0];
                        mode       <= regs0[16];
                        step       <= regs1;
                        requested  <= '0;
                        written    <= '0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (rd_fire)
                        requested <= requested + 1'b1;
                    if (requested == num_values)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (written_nxt == num_values) begin
                        op_done <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/pipearch_modify.md
Name: pipearch_modify

Overview:
- Downstream stage of the dot-product engine; consumes one 32-bit dot result per sample and the matching 32-bit label.
- Produces a step-scaled gradient scalar per sample: linear-regression residual or SVM hinge subgradient, fixed-point Q16.16.
- Scalars go to a FIFO read by the model-update stage.
- Programmed per operation through regs0/regs1 with an op_start/op_done handshake.

Parameters:
- FRAC_BITS, 16, fractional bits of the Q format used for labels, dot results, step size and output.
- NUM_VALUES_WIDTH, 16, width of the per-operation sample counter.

Ports:
- clk  input  1  clock
- resetn  input  1  synchronous active-low reset
- op_start  input  1  one-cycle start pulse, sampled only in IDLE
- op_done  output  1  one-cycle completion pulse
- regs0  input  32  [15:0] num_values; [16] mode (0 = linreg, 1 = hinge)
- regs1  input  32  step size, signed Q16.16
- dot_input  fifobram_interface.fifo_read  32  dot results; uses re, rvalid, rdata[31:0], empty
- labels_input  fifobram_interface.fifo_read  32  labels; uses re, rvalid, rdata[31:0], empty
- modify_output  fifobram_interface.fifo_write  32  scalars; uses we, wdata[31:0], almostfull

Behaviour:
- Reset (resetn=0 at a clock edge): state IDLE; op_done, both re, we = 0; wdata = 0; counters = 0; pipeline valids = 0. Reset mid-operation abandons it with no op_done; FIFO contents are untouched.
- FIFO read latency is 1: rvalid/rdata follow re by one cycle. Both inputs are read in lockstep, so their rvalids coincide.
- States:
  - IDLE: on op_start, latch num_values, mode and step. Clear requested/written counters. Go to RUN.
  - RUN: assert both re together when !dot_input.empty && !labels_input.empty && !modify_output.almostfull && requested < num_values; requested increments. When requested == num_values, go to DRAIN.
  - DRAIN: wait until written == num_values, then pulse op_done for one cycle and return to IDLE.
- num_values = 0: no reads and no writes; op_done pulses the cycle after the RUN->DRAIN->IDLE path completes, within 3 cycles of op_start. op_start outside IDLE is ignored.
- Pipeline (t = cycle in which rvalid = 1):
  - S1, registered at t+1:
    - mode 0: diff = dot - label (32-bit wrap).
    - mode 1: margin = label[31] ? -dot : dot; diff = (margin < 0x00010000 signed) ? -label : 0.
  - S2, registered at t+2: prod = signed(diff) * signed(step), 64-bit. modify_output.we = 1, wdata = prod[47:16] (arithmetic >>> FRAC_BITS, truncation toward -inf, no saturation). written increments.
- Latency is exactly 2 cycles from rvalid to we. Throughput is 1 sample/cycle.
- Back-pressure: almostfull must assert with >= 3 free entries; the block never drops data and never writes when the FIFO is full.
- Simultaneous empty on one input blocks both reads; inputs never desynchronise.

Decomposition:
- Shared package pipearch_pkg: t_modify_state enum (IDLE, RUN, DRAIN), mode constants MODIFY_LINREG = 0 and MODIFY_HINGE = 1, Q16.16 constant FIXED_ONE = 32'h00010000.
- One natural sub-module: pipearch_modify_datapath, holding the S1/S2 registers and the multiply, with valid-in/valid-out and mode/step inputs. The FSM and counters stay in the top.

Test Plan:
- Linreg, num_values = 3, step = 0x00008000 (0.5); dots {0x00030000, 0x00010000, 0}; labels {0x00010000, 0x00010000, 0x00020000} -> wdata {0x00010000, 0, 0xFFFF0000}; op_done one cycle after the last we.
- Hinge, step = 0x00010000; (dot 0x00008000, label 0x00010000) -> 0xFFFF0000; (dot 0x00020000, label 0x00010000) -> 0; (dot 0x00008000, label 0xFFFF0000) -> 0x00010000.
- Back-pressure: almostfull held high for 10 cycles mid-stream with 8 samples -> no re while high; all 8 outputs correct and in order; exactly one op_done.
- Starvation: labels_input empty while dot_input holds data -> neither re asserted; the stream resumes correctly when labels arrive.
- num_values = 0 -> no re and no we; op_done within 3 cycles of op_start.
- resetn = 0 for 1 cycle mid-stream of 16 samples -> outputs/state cleared, no op_done; a subsequent op_start with 2 samples completes correctly.
